// File: rtl/pacman_display_pkg.sv
// Shared display definitions: requester indices, VGA field widths and
// the plot-arbiter state encoding.
package pacman_display_pkg;

    localparam int REQ_MAP     = 0;
    localparam int REQ_CHAR    = 1;
    localparam int REQ_ERASE   = 2;

    localparam int VGA_XY_W    = 8;
    localparam int VGA_COLOR_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_request_picker.sv
// Rotating-priority encoder: scans req starting at rr_ptr and wrapping,
// returns the first requester found as an index and as a one-hot vector.
module rr_request_picker #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               valid
);

    logic [PTR_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi positions after the pointer.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign cand_idx[gi] = PTR_W'((int'(rr_ptr) + gi) % NUM_REQ);
        assign cand_hit[gi] = req[cand_idx[gi]];
    end

    // Lowest rotated position wins, so scan from the far end downwards.
    always_comb begin
        pick_idx = '0;
        valid    = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                pick_idx = cand_idx[k];
                valid    = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
        assign pick[gi] = valid && (pick_idx == PTR_W'(gi));
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA plot port. One requester at a time
// gets a burst (ended by done, dropped req, or the burst cap), followed by
// an idle gap with no owner and no plotting.
module vga_plot_arbiter
    import pacman_display_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int MAX_BURST  = 12000,
    parameter int GAP_CYCLES = 2
) (
    input  logic                           clock_50,
    input  logic                           reset,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             done,
    input  logic [NUM_REQ-1:0]             plot_in,
    input  logic [VGA_XY_W*NUM_REQ-1:0]    x_in,
    input  logic [VGA_XY_W*NUM_REQ-1:0]    y_in,
    input  logic [VGA_COLOR_W*NUM_REQ-1:0] color_in,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           vga_plot,
    output logic [VGA_XY_W-1:0]            vga_x,
    output logic [VGA_XY_W-1:0]            vga_y,
    output logic [VGA_COLOR_W-1:0]         vga_color,
    output logic                           busy,
    output logic [NUM_REQ-1:0]             timeout
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    arb_state_t           state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 vga_plot_q, vga_plot_d;
    logic [VGA_XY_W-1:0]  vga_x_q, vga_x_d;
    logic [VGA_XY_W-1:0]  vga_y_q, vga_y_d;
    logic [VGA_COLOR_W-1:0] vga_color_q, vga_color_d;
    logic [NUM_REQ-1:0]   timeout_q, timeout_d;

    logic [VGA_XY_W-1:0]    x_arr [NUM_REQ];
    logic [VGA_XY_W-1:0]    y_arr [NUM_REQ];
    logic [VGA_COLOR_W-1:0] c_arr [NUM_REQ];

    logic [NUM_REQ-1:0] pick;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               released;
    logic               capped;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign x_arr[gi] = x_in[gi*VGA_XY_W +: VGA_XY_W];
        assign y_arr[gi] = y_in[gi*VGA_XY_W +: VGA_XY_W];
        assign c_arr[gi] = color_in[gi*VGA_COLOR_W +: VGA_COLOR_W];
    end

    rr_request_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req      (req),
        .rr_ptr   (rr_ptr_q),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Next-state, counters and the owner-to-VGA forwarding path.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        vga_plot_d  = 1'b0;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        timeout_d   = timeout_q;
        released    = 1'b0;
        capped      = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (en && pick_valid) begin
                    state_d     = ARB_GRANT;
                    grant_d     = pick;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            ARB_GRANT: begin
                // The exit cycle's strobe is still forwarded.
                vga_plot_d  = plot_in[owner_q];
                vga_x_d     = x_arr[owner_q];
                vga_y_d     = y_arr[owner_q];
                vga_color_d = c_arr[owner_q];
                burst_cnt_d = burst_cnt_q + CNT_W'(1);
                released    = done[owner_q] || !req[owner_q];
                capped      = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
                if (released || capped) begin
                    state_d   = ARB_GAP;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    rr_ptr_d  = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
                    // A voluntary release on the cap cycle is not a pre-emption.
                    if (capped && !released) begin
                        timeout_d[owner_q] = 1'b1;
                    end
                end
            end
            ARB_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = ARB_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            gap_cnt_q   <= '0;
            vga_plot_q  <= 1'b0;
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            timeout_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            vga_plot_q  <= vga_plot_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant     = grant_q;
    assign vga_plot  = vga_plot_q;
    assign vga_x     = vga_x_q;
    assign vga_y     = vga_y_q;
    assign vga_color = vga_color_q;
    assign busy      = (state_q != ARB_IDLE);
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: one instance with the full-size burst cap and
// one with a cap of 8; plotted pixels are scoreboarded, grant order is
// checked against an expected-owner queue.
module tb_vga_plot_arbiter;
    import pacman_display_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] c;
    } pix_t;

    logic clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    logic        reset, en, sel_cap;
    logic [2:0]  req, done, plot_in;
    logic [23:0] x_in, y_in;
    logic [8:0]  color_in;

    logic [2:0] grant_a, timeout_a, color_a, grant_b, timeout_b, color_b;
    logic       plot_a, busy_a, plot_b, busy_b;
    logic [7:0] x_a, y_a, x_b, y_b;

    vga_plot_arbiter #(.NUM_REQ(3), .MAX_BURST(12000), .GAP_CYCLES(2)) dut_main (
        .clock_50(clock_50), .reset(reset), .en(en), .req(req), .done(done),
        .plot_in(plot_in), .x_in(x_in), .y_in(y_in), .color_in(color_in),
        .grant(grant_a), .vga_plot(plot_a), .vga_x(x_a), .vga_y(y_a),
        .vga_color(color_a), .busy(busy_a), .timeout(timeout_a)
    );

    vga_plot_arbiter #(.NUM_REQ(3), .MAX_BURST(8), .GAP_CYCLES(2)) dut_cap (
        .clock_50(clock_50), .reset(reset), .en(en), .req(req), .done(done),
        .plot_in(plot_in), .x_in(x_in), .y_in(y_in), .color_in(color_in),
        .grant(grant_b), .vga_plot(plot_b), .vga_x(x_b), .vga_y(y_b),
        .vga_color(color_b), .busy(busy_b), .timeout(timeout_b)
    );

    // Outputs of whichever instance the current test targets.
    logic [2:0] m_grant, m_timeout, m_color;
    logic       m_plot, m_busy;
    logic [7:0] m_x, m_y;
    assign m_grant   = sel_cap ? grant_b   : grant_a;
    assign m_timeout = sel_cap ? timeout_b : timeout_a;
    assign m_color   = sel_cap ? color_b   : color_a;
    assign m_plot    = sel_cap ? plot_b    : plot_a;
    assign m_busy    = sel_cap ? busy_b    : busy_a;
    assign m_x       = sel_cap ? x_b       : x_a;
    assign m_y       = sel_cap ? y_b       : y_a;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    pix_t sb [$];
    logic [2:0] exp_grant_q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Advance one clock, sample just after the edge, retire any plotted pixel.
    task automatic step();
        pix_t e;
        @(posedge clock_50);
        #1;
        cyc++;
        check_eq("grant_onehot", ($countones(m_grant) <= 1), 1);
        if (m_plot) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("plot_x", m_x, e.x);
                check_eq("plot_y", m_y, e.y);
                check_eq("plot_color", m_color, e.c);
                $display("cycle %0d plot x=%02h y=%02h c=%0d", cyc, m_x, m_y, m_color);
            end else begin
                check_eq("sb_unexpected_plot", m_plot, 1'b0);
            end
        end
    endtask

    // Drive requester r's pixel; push it when it should reach the VGA port.
    task automatic drive_pix(input int r, input logic [7:0] x, input logic [7:0] y,
                             input logic [2:0] c, input bit fwd);
        pix_t p;
        plot_in[r]        = 1'b1;
        x_in[r*8 +: 8]    = x;
        y_in[r*8 +: 8]    = y;
        color_in[r*3 +: 3] = c;
        if (fwd) begin
            p.x = x; p.y = y; p.c = c;
            sb.push_back(p);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b1; req = '0; done = '0; plot_in = '0;
        sb.delete();
        exp_grant_q.delete();
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] prev;
        logic [2:0] g;
        int own, zero_run, ngrants;

        reset = 1'b1; en = 1'b0; sel_cap = 1'b0;
        req = '0; done = '0; plot_in = '0; x_in = '0; y_in = '0; color_in = '0;

        // ---- reset state ----
        do_reset();
        check_eq("rst_grant", grant_a, 3'b000);
        check_eq("rst_plot", plot_a, 1'b0);
        check_eq("rst_xy", {x_a, y_a}, 16'h0);
        check_eq("rst_color", color_a, 3'd0);
        check_eq("rst_busy", busy_a, 1'b0);
        check_eq("rst_timeout", timeout_a, 3'b000);

        // ---- 1: single requester, 10 plots, done ----
        en = 1'b0; req = 3'b001;
        step();
        check_eq("t1_en_low_grant", m_grant, 3'b000);
        check_eq("t1_en_low_busy", m_busy, 1'b0);
        en = 1'b1;
        step();
        check_eq("t1_grant_latency", m_grant, 3'b001);
        check_eq("t1_busy_grant", m_busy, 1'b1);
        for (int i = 0; i < 10; i++) begin
            plot_in = '0;
            drive_pix(0, 8'(8'h10 + i), 8'(8'h20 + i), 3'(i), 1'b1);
            done = (i == 9) ? 3'b001 : 3'b000;
            step();
            if (i < 9) check_eq("t1_grant_hold", m_grant, 3'b001);
        end
        // Exit edge: grant gone, last plot forwarded, GAP begins.
        check_eq("t1_release", m_grant, 3'b000);
        check_eq("t1_gap1_busy", m_busy, 1'b1);
        done = '0; plot_in = '0; req = '0;
        step();
        check_eq("t1_gap2_busy", m_busy, 1'b1);
        check_eq("t1_gap_plot", m_plot, 1'b0);
        check_eq("t1_gap_x_hold", m_x, 8'h19);
        step();
        check_eq("t1_idle_busy", m_busy, 1'b0);
        check_eq("t1_sb_drained", sb.size(), 0);

        // ---- 2: all requesting, round-robin order and gaps ----
        do_reset();
        exp_grant_q.push_back(3'b001);
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b100);
        exp_grant_q.push_back(3'b001);
        req = 3'b111;
        prev = '0; own = 0; zero_run = 0; ngrants = 0;
        for (int k = 0; k < 200 && ngrants < 4; k++) begin
            step();
            done = '0;
            if (m_grant != 0) begin
                if (prev == 0) begin
                    ngrants++;
                    g = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 3'b000;
                    check_eq("t2_order", m_grant, g);
                    $display("cycle %0d grant %b", cyc, m_grant);
                    // GAP_CYCLES of GAP plus the IDLE arbitration cycle.
                    if (ngrants > 1) check_eq("t2_gap_len", zero_run, 3);
                    own = 0;
                end
                own++;
                if (own == 5) done = m_grant;
            end else begin
                if (prev != 0) check_eq("t2_burst_len", own, 5);
                zero_run = (prev != 0) ? 1 : zero_run + 1;
            end
            prev = m_grant;
        end
        check_eq("t2_order_drained", exp_grant_q.size(), 0);
        req = '0; done = '0;
        step(); step(); step(); step();

        // ---- 3: burst cap pre-empts requester 1 ----
        sel_cap = 1'b1;
        do_reset();
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b010);
        exp_grant_q.push_back(3'b100);
        req = 3'b010;
        prev = '0; own = 0; ngrants = 0;
        for (int k = 0; k < 200 && ngrants < 3; k++) begin
            step();
            if (m_grant != 0) begin
                if (prev == 0) begin
                    ngrants++;
                    g = (exp_grant_q.size() > 0) ? exp_grant_q.pop_front() : 3'b000;
                    check_eq("t3_order", m_grant, g);
                    $display("cycle %0d grant %b timeout %b", cyc, m_grant, m_timeout);
                    own = 0;
                    if (ngrants == 2) req = 3'b110;
                    if (ngrants == 3) begin
                        check_eq("t3_timeout_sticky", m_timeout, 3'b010);
                        req = '0;
                    end
                end
                own++;
            end else if (prev != 0) begin
                check_eq("t3_cap_len", own, 8);
                check_eq("t3_timeout", m_timeout, 3'b010);
            end
            prev = m_grant;
        end
        check_eq("t3_order_drained", exp_grant_q.size(), 0);
        step(); step();
        check_eq("t3_drop_release", m_grant, 3'b000);
        check_eq("t3_timeout_final", m_timeout, 3'b010);

        // ---- 4: done coincides with the cap ----
        do_reset();
        req = 3'b001;
        step();
        check_eq("t4_grant", m_grant, 3'b001);
        for (int s = 2; s <= 8; s++) begin
            step();
            check_eq("t4_hold", m_grant, 3'b001);
        end
        done = 3'b001;
        step();
        done = '0; req = '0;
        check_eq("t4_release", m_grant, 3'b000);
        check_eq("t4_no_timeout", m_timeout, 3'b000);
        step(); step(); step();

        // ---- 5: non-owner plot ignored ----
        sel_cap = 1'b0;
        do_reset();
        req = 3'b101;
        step();
        check_eq("t5_grant", m_grant, 3'b001);
        for (int i = 0; i < 8; i++) begin
            plot_in = '0;
            drive_pix(2, 8'h55, 8'h66, 3'd7, 1'b0);
            if (i % 2 == 1) begin
                drive_pix(0, 8'(8'h30 + i), 8'(8'h40 + i), 3'(i), 1'b1);
            end else begin
                x_in[7:0] = 8'(8'h30 + i);
            end
            if (i == 7) begin
                done = 3'b001;
                req  = 3'b000;
            end
            step();
            check_eq("t5_x_not_55", (m_x == 8'h55), 1'b0);
        end
        done = '0; plot_in = '0;
        step();
        check_eq("t5_x_not_55_exit", (m_x == 8'h55), 1'b0);
        step(); step();
        check_eq("t5_sb_drained", sb.size(), 0);

        // ---- 6: reset mid-burst clears rr_ptr ----
        do_reset();
        req = 3'b010;
        step();
        check_eq("t6_pre_grant", m_grant, 3'b010);
        done = 3'b010;
        step();
        done = '0; req = '0;
        step(); step();
        // rr_ptr now points at requester 2; only requester 0 asks.
        req = 3'b001;
        step();
        check_eq("t6_grant0", m_grant, 3'b001);
        for (int s = 1; s <= 3; s++) begin
            plot_in = '0;
            drive_pix(0, 8'(8'h70 + s), 8'(8'h80 + s), 3'(s), 1'b1);
            step();
        end
        plot_in = '0;
        drive_pix(0, 8'hAA, 8'hBB, 3'd5, 1'b0);
        reset = 1'b1;
        step();
        check_eq("t6_rst_grant", m_grant, 3'b000);
        check_eq("t6_rst_plot", m_plot, 1'b0);
        check_eq("t6_rst_busy", m_busy, 1'b0);
        check_eq("t6_rst_x", m_x, 8'h00);
        reset = 1'b0; plot_in = '0; req = 3'b110;
        step();
        check_eq("t6_rr_ptr_reset", m_grant, 3'b010);
        req = '0;
        step(); step(); step();
        check_eq("t6_sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
